cmd_link_slave: RTL and testbench
=================================

// Module: cmd_link_slave
// PURPOSE
//  Copter-side end of the wireless command link; the counterpart of the master that sends commands.
//  Receives 3-byte 8N1 UART frames: cmd, data[15:8], data[7:0].
//  Presents cmd/data with a cmd_rdy flag to the flight command handler.
//  Serialises the handler's 1-byte response (e.g. pos-ack) back on TX.
// PARAMETERS
//  BAUD_DIV     2604    clk cycles per UART bit (50 MHz / 19200 baud)
//  FRM_TO_CYC   500000  max idle clk cycles between bytes of one frame (used only with CMD_FRM_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  RX           in   1   serial in from master (async, idle high)
//  TX           out  1   serial out to master (idle high)
//  cmd          out  8   opcode of last complete frame
//  data         out  16  payload of last complete frame
//  cmd_rdy      out  1   complete frame valid
//  clr_cmd_rdy  in   1   handler consumed cmd/data
//  resp         in   8   response byte to send
//  send_resp    in   1   1-cycle strobe: start transmitting resp
//  tx_busy      out  1   transmitter active
//  resp_sent    out  1   1-cycle pulse: response stop bit finished
// BEHAVIOUR
//  Reset: TX=1, cmd=0, data=0, cmd_rdy=0, tx_busy=0, resp_sent=0.
//   Frame FSM to WAIT_CMD; RX synchroniser flops preset to 1.
//  RX bit level:
//   - RX passes through a 2-flop synchroniser.
//   - A falling edge while idle starts a bit counter; sampling occurs at BAUD_DIV/2, then every BAUD_DIV.
//   - If the start bit samples high: abort; no byte is produced.
//   - 8 data bits, LSB first.
//   - If the stop bit samples low: framing error. Discard the byte and return the frame FSM to WAIT_CMD.
//   - A good byte produces a 1-cycle byte_vld at the stop-bit sample.
//  Frame FSM: WAIT_CMD -> WAIT_HI -> WAIT_LO -> WAIT_CMD, advancing on each byte_vld.
//   - Bytes are held in shadow registers; cmd/data are not disturbed until the frame completes.
//   - On the WAIT_LO byte: cmd, data and cmd_rdy=1 are all updated in the next cycle (atomic).
//   - cmd_rdy clears on clr_cmd_rdy, or on byte_vld in WAIT_CMD (start of next frame).
//   - If frame completion and clr_cmd_rdy occur in the same cycle, set wins.
//   - A new frame overwrites cmd/data even when cmd_rdy was never cleared (no backpressure).
//  TX:
//   - send_resp while !tx_busy: latch resp; tx_busy=1 next cycle; start bit drives TX in that cycle.
//   - Output is start, 8 data LSB first, stop; each bit lasts BAUD_DIV cycles.
//   - tx_busy falls and resp_sent pulses in the cycle after the stop bit completes.
//     Total = 10*BAUD_DIV+1 cycles from send_resp to resp_sent.
//   - send_resp while tx_busy is ignored (no queue).
//  RX and TX are fully independent, so full duplex is allowed.
//  rst mid-byte or mid-frame: everything is abandoned; the line is re-acquired on the next falling edge.
// CONFIGURATION
//  CMD_FRM_TIMEOUT_EN defined:
//   - An idle counter runs while the FSM is in WAIT_HI/WAIT_LO and no byte is in progress.
//   - It clears on each start bit.
//   - Reaching FRM_TO_CYC returns the FSM to WAIT_CMD; partial bytes are dropped and cmd_rdy is unaffected.
//  Not defined: no counter. A partial frame waits indefinitely; only a framing error or rst resyncs it.
// STRUCTURE
//  comm_pkg:
//   - frm_state_t enum {WAIT_CMD, WAIT_HI, WAIT_LO}
//   - opcodes CMD_SET_PTCH=8'h02, CMD_SET_THRST=8'h05, CMD_CALIBRATE=8'h06
//   - POS_ACK=8'hA5
//  Sub-module uart_xcvr: bit-level RX (byte_vld, rx_byte, frm_err) and TX (trmt, tx_byte, tx_done).
//  cmd_link_slave holds only the frame FSM, the timeout and the output registers.
// TESTING
//  1. Master sends 05,01,FF -> cmd_rdy rises once; cmd=8'h05, data=16'h01FF.
//     Before completion, cmd/data hold their previous values.
//  2. cmd_rdy=1, then master sends 02,40,00 without clr -> cmd_rdy falls at the first byte and rises at the third;
//     data=16'h4000.
//  3. send_resp with resp=8'hA5 -> TX carries 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV each.
//     resp_sent pulses exactly 10*BAUD_DIV+1 cycles after send_resp.
//     A second send_resp mid-transfer is ignored.
//  4. Stop bit forced low on the 2nd byte -> no cmd_rdy.
//     A following clean 06,00,00 frame gives cmd=8'h06, data=16'h0000.
//  5. rst asserted mid-byte of the 3rd byte -> all outputs return to their reset values.
//     The next full frame decodes correctly.
//  6. CMD_FRM_TIMEOUT_EN: send 05 then idle FRM_TO_CYC+10 cycles, then 02,12,34 -> cmd=8'h02, data=16'h1234.
//     Without the macro, the same stimulus gives cmd=8'h05, data=16'h0212.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types and constants for the wireless command link.
// Frame states, command opcodes and the positive-acknowledge response byte.
package comm_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } frm_state_t;

  localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
  localparam logic [7:0] CMD_SET_THRST = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE = 8'h06;

  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/uart_xcvr.sv
// Bit-level 8N1 UART receiver and transmitter sharing one baud divisor.
// CMD_FRM_TIMEOUT_EN exposes rx_busy so the frame layer can time out idle gaps.
module uart_xcvr #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       frm_err,
`ifdef CMD_FRM_TIMEOUT_EN
  output logic       rx_busy,
`endif
  input  logic       trmt,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV);

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          rx_busy_q, rx_busy_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_fall, rx_smp;

  logic          tx_q, tx_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_shift_q, tx_shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_busy_q <= rx_busy_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
  end

  // Receiver: bit 0 is the start bit, 1..8 data, 9 stop; samples land mid-cell.
  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_smp  = rx_busy_q && (rx_cnt_q == '0);

  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    if (!rx_busy_q) begin
      if (rx_fall) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = CW'(BAUD_DIV / 2 - 1);
        rx_bit_d  = 4'd0;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = CW'(BAUD_DIV - 1);
      rx_bit_d = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0 && rx_s2_q) begin
        rx_busy_d = 1'b0;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
      end else if (rx_bit_q != 4'd0) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
      end
    end
  end

  assign byte_vld = rx_smp && (rx_bit_q == 4'd9) && rx_s2_q;
  assign frm_err  = rx_smp && (rx_bit_q == 4'd9) && !rx_s2_q;
  assign rx_byte  = rx_shift_q;
`ifdef CMD_FRM_TIMEOUT_EN
  assign rx_busy  = rx_busy_q;
`endif

  // Transmitter: the stop bit rides in the top of the shift register.
  always_comb begin
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (trmt && !tx_busy_q) begin
      tx_busy_d  = 1'b1;
      tx_d       = 1'b0;
      tx_shift_d = {1'b1, tx_byte};
      tx_cnt_d   = CW'(BAUD_DIV - 1);
      tx_bit_d   = 4'd0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_d = tx_cnt_q - 1'b1;
      end else if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
        tx_d      = 1'b1;
      end else begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_cnt_d   = CW'(BAUD_DIV - 1);
      end
    end
  end

  assign TX      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/cmd_link_slave.sv
// Copter-side command link: assembles 3-byte frames into cmd/data and sends 1-byte responses.
// Define CMD_FRM_TIMEOUT_EN to drop partial frames after FRM_TO_CYC idle cycles.
module cmd_link_slave
  import comm_pkg::*;
#(
  parameter int BAUD_DIV   = 2604,
  parameter int FRM_TO_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  frm_state_t  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  sh_cmd_q, sh_cmd_d;
  logic [7:0]  sh_hi_q, sh_hi_d;
  logic        byte_vld, frm_err, frm_to;
  logic [7:0]  rx_byte;

  if (FRM_TO_CYC < 1) begin : g_bad_to
    $error("FRM_TO_CYC must be positive");
  end

`ifdef CMD_FRM_TIMEOUT_EN
  localparam int TW = $clog2(FRM_TO_CYC + 1);
  logic          rx_busy;
  logic [TW-1:0] idle_q, idle_d;
`endif

  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .TX       (TX),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte),
    .frm_err  (frm_err),
`ifdef CMD_FRM_TIMEOUT_EN
    .rx_busy  (rx_busy),
`endif
    .trmt     (send_resp),
    .tx_byte  (resp),
    .tx_busy  (tx_busy),
    .tx_done  (resp_sent)
  );

`ifdef CMD_FRM_TIMEOUT_EN
  // Counts only the gaps between bytes of a started frame; any start bit restarts it.
  always_comb begin
    idle_d = '0;
    frm_to = 1'b0;
    if (state_q != WAIT_CMD && !rx_busy) begin
      if (idle_q == TW'(FRM_TO_CYC - 1)) frm_to = 1'b1;
      else idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign frm_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_CMD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frm_err || frm_to) begin
      state_d = WAIT_CMD;
    end else if (byte_vld) begin
      case (state_q)
        WAIT_CMD: state_d = WAIT_HI;
        WAIT_HI:  state_d = WAIT_LO;
        default:  state_d = WAIT_CMD;
      endcase
    end
  end

  // Shadow bytes keep cmd/data stable until the last byte lands, then all three update together.
  always_comb begin
    cmd_d    = cmd_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    sh_cmd_d = sh_cmd_q;
    sh_hi_d  = sh_hi_q;
    if (clr_cmd_rdy) rdy_d = 1'b0;
    if (byte_vld) begin
      case (state_q)
        WAIT_CMD: begin
          sh_cmd_d = rx_byte;
          rdy_d    = 1'b0;
        end
        WAIT_HI: sh_hi_d = rx_byte;
        default: begin
          cmd_d  = sh_cmd_q;
          data_d = {sh_hi_q, rx_byte};
          rdy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      data_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_cmd_q <= sh_cmd_d;
    sh_hi_q  <= sh_hi_d;
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = rdy_q;

endmodule

// File: tb/tb_cmd_link_slave.sv
// Directed bench for cmd_link_slave with a short baud divisor and frame timeout.
// Expectations for the idle-gap scenario follow CMD_FRM_TIMEOUT_EN.
module tb_cmd_link_slave;

  localparam int B  = 16;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        tx_busy;
  logic        resp_sent;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic rdy_prev = 1'b0;

  cmd_link_slave #(.BAUD_DIV(B), .FRM_TO_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rises++;
    rdy_prev = cmd_rdy;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    RX = 1'b0;
    idle(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      idle(B);
    end
    RX = stop;
    idle(B);
    RX = 1'b1;
  endtask

  task automatic pulse_clr;
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_TX got %b exp 1", TX); end
    checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h exp 00", cmd); end
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", data); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", cmd_rdy); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_sent got %b exp 0", resp_sent); end
  endtask

  task automatic test_frame;
    int r0;
    r0 = rises;
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    @(negedge clk);
    checks++; if (cmd !== 8'h00 || data !== 16'h0000 || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL frame_hold got %h/%h/%b exp 00/0000/0", cmd, data, cmd_rdy); end
    send_byte(8'hFF, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (cmd !== 8'h05) begin errors++; $display("FAIL frame_cmd got %h exp 05", cmd); end
    checks++; if (data !== 16'h01FF) begin errors++; $display("FAIL frame_data got %h exp 01ff", data); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL frame_rdy got %b exp 1", cmd_rdy); end
    checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL frame_rises got %0d exp 1", rises - r0); end
  endtask

  task automatic test_no_clr;
    send_byte(8'h02, 1'b1);
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL noclr_fall got %b exp 0", cmd_rdy); end
    checks++; if (cmd !== 8'h05 || data !== 16'h01FF) begin
      errors++; $display("FAIL noclr_hold got %h/%h exp 05/01ff", cmd, data); end
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (cmd !== 8'h02 || data !== 16'h4000) begin
      errors++; $display("FAIL noclr_frame got %h/%h exp 02/4000", cmd, data); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL noclr_rdy got %b exp 1", cmd_rdy); end
  endtask

  task automatic test_tx;
    logic [9:0] exp_bits;
    int n, sent_cnt, sent_at;
    exp_bits = 10'b1_1010_0101_0;
    sent_cnt = 0;
    sent_at  = -1;
    pulse_clr;
    @(posedge clk); #1;
    resp = 8'hA5; send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0; resp = 8'h00;
    n = 1;
    while (n <= 10 * B + 4) begin
      @(negedge clk);
      if (n == 1) begin
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_rise got %b exp 1", tx_busy); end
      end
      if (n == 10 * B) begin
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_stop got %b exp 1", tx_busy); end
      end
      if (n <= 10 * B && ((n - 1) % B) == B / 2) begin
        checks++; if (TX !== exp_bits[(n - 1) / B]) begin
          errors++; $display("FAIL tx_bit%0d got %b exp %b", (n - 1) / B, TX, exp_bits[(n - 1) / B]); end
      end
      if (resp_sent === 1'b1) begin sent_cnt++; sent_at = n; end
      @(posedge clk); #1;
      if (n == 3 * B) begin send_resp = 1'b1; resp = 8'h0F; end
      else send_resp = 1'b0;
      n++;
    end
    checks++; if (sent_cnt !== 1) begin errors++; $display("FAIL tx_sent_count got %0d exp 1", sent_cnt); end
    checks++; if (sent_at !== 10 * B + 1) begin errors++; $display("FAIL tx_sent_time got %0d exp %0d", sent_at, 10 * B + 1); end
    checks++; if (tx_busy !== 1'b0 || TX !== 1'b1) begin
      errors++; $display("FAIL tx_idle got %b/%b exp 0/1", tx_busy, TX); end
  endtask

  task automatic test_frm_err;
    int r0;
    r0 = rises;
    send_byte(8'h05, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(2 * B);
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b0 || rises != r0) begin
      errors++; $display("FAIL ferr_rdy got %b rises %0d exp 0 rises %0d", cmd_rdy, rises, r0); end
    checks++; if (cmd !== 8'h02) begin errors++; $display("FAIL ferr_cmd_hold got %h exp 02", cmd); end
    send_byte(8'h06, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (cmd !== 8'h06 || data !== 16'h0000 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL ferr_recover got %h/%h/%b exp 06/0000/1", cmd, data, cmd_rdy); end
  endtask

  task automatic test_rst_mid;
    @(posedge clk); #1;
    resp = 8'hA5; send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    @(posedge clk); #1;
    RX = 1'b0;
    idle(B);
    RX = 1'b1;
    idle(B);
    RX = 1'b0;
    idle(B / 2);
    rst = 1'b1;
    idle(3);
    RX = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (TX !== 1'b1 || tx_busy !== 1'b0 || resp_sent !== 1'b0) begin
      errors++; $display("FAIL rst_tx got %b/%b/%b exp 1/0/0", TX, tx_busy, resp_sent); end
    checks++; if (cmd !== 8'h00 || data !== 16'h0000 || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_cmd got %h/%h/%b exp 00/0000/0", cmd, data, cmd_rdy); end
    idle(4);
    send_byte(8'h05, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (cmd !== 8'h05 || data !== 16'hABCD || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_frame got %h/%h/%b exp 05/abcd/1", cmd, data, cmd_rdy); end
  endtask

  task automatic test_timeout;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
    logic        exp_rdy;
`ifdef CMD_FRM_TIMEOUT_EN
    exp_cmd = 8'h02; exp_data = 16'h1234; exp_rdy = 1'b1;
`else
    exp_cmd = 8'h05; exp_data = 16'h0212; exp_rdy = 1'b0;
`endif
    pulse_clr;
    send_byte(8'h05, 1'b1);
    idle(TO + 10);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (cmd !== exp_cmd || data !== exp_data) begin
      errors++; $display("FAIL timeout_frame got %h/%h exp %h/%h", cmd, data, exp_cmd, exp_data); end
    checks++; if (cmd_rdy !== exp_rdy) begin
      errors++; $display("FAIL timeout_rdy got %b exp %b", cmd_rdy, exp_rdy); end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_no_clr;
    test_tx;
    test_frm_err;
    test_rst_mid;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
